// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: rd-write scoreboard for RAW/WAW stalls, redirect flush, drain.
// Stall/flush/ack are combinational in the decision cycle; scoreboard and counters update on the next edge.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rd_write_enable,
  input  logic [4:0]       id_rd_write_addr,
  input  logic             wb_valid,
  input  logic             wb_rd_write_enable,
  input  logic [4:0]       wb_rd_write_addr,
  input  logic             redirect,
  input  logic             drain_req,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             drain_ack,
  output logic [31:0]      busy_regs,
  output logic [CNT_W-1:0] stall_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t           r_state;
  logic [FC_W-1:0]  r_flush_cnt;
  logic [31:0]      r_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  logic        w_hazard;
  logic        w_flush;
  logic        w_stall;
  logic        w_ack;
  logic        w_issue;
  logic        w_retire;
  logic        w_empty;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_busy_nxt;

  // Hazard looks only at the registered scoreboard: a retire frees its register a cycle later.
  assign w_hazard = id_valid & ((id_uses_rs1 & r_busy[id_rs1_addr]) |
                                (id_uses_rs2 & r_busy[id_rs2_addr]) |
                                (id_rd_write_enable & r_busy[id_rd_write_addr]));
  assign w_empty  = (r_busy == 32'd0);
  assign w_flush  = ~rst & (redirect | (r_state == S_FLUSH));
  assign w_stall  = ~rst & ~w_flush & (((r_state == S_RUN) & w_hazard) | (r_state == S_DRAIN));
  assign w_ack    = ~rst & (r_state == S_DRAIN) & ~redirect & w_empty;

  assign w_issue  = id_valid & id_rd_write_enable & (id_rd_write_addr != 5'd0) & ~w_stall & ~w_flush;
  assign w_retire = wb_valid & wb_rd_write_enable & (wb_rd_write_addr != 5'd0);
  assign w_set    = w_issue  ? (32'd1 << id_rd_write_addr) : 32'd0;
  assign w_clr    = w_retire ? (32'd1 << wb_rd_write_addr) : 32'd0;
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;

  assign stall_if    = w_stall;
  assign stall_id    = w_stall;
  assign flush_id    = w_flush;
  assign flush_ex    = w_flush;
  assign drain_ack   = w_ack;
  assign busy_regs   = r_busy;
  assign stall_count = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 32'd0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Redirect wins from any state; a drain it interrupts is re-entered later from RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
    end else if (redirect) begin
      r_flush_cnt <= FC_LOAD;
      r_state     <= (FC_LOAD != '0) ? S_FLUSH : S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (drain_req)
            r_state <= S_DRAIN;
        end
        S_FLUSH: begin
          if (r_flush_cnt <= FC_W'(1)) begin
            r_flush_cnt <= '0;
            r_state     <= S_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_empty)
            r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand sequences, randomized run vs. model.
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_rd_write_enable;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_write_addr;
  logic wb_valid, wb_rd_write_enable;
  logic [4:0] wb_rd_write_addr;
  logic redirect, drain_req;

  logic stall_if, stall_id, flush_id, flush_ex, drain_ack;
  logic [31:0] busy_regs;
  logic [15:0] stall_count;
  logic stall_if4, stall_id4, flush_id4, flush_ex4, drain_ack4;
  logic [31:0] busy_regs4;
  logic [3:0]  stall_count4;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_write_enable(id_rd_write_enable),
    .id_rd_write_addr(id_rd_write_addr), .wb_valid(wb_valid), .wb_rd_write_enable(wb_rd_write_enable),
    .wb_rd_write_addr(wb_rd_write_addr), .redirect(redirect), .drain_req(drain_req),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .drain_ack(drain_ack), .busy_regs(busy_regs), .stall_count(stall_count));

  hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_write_enable(id_rd_write_enable),
    .id_rd_write_addr(id_rd_write_addr), .wb_valid(wb_valid), .wb_rd_write_enable(wb_rd_write_enable),
    .wb_rd_write_addr(wb_rd_write_addr), .redirect(redirect), .drain_req(drain_req),
    .stall_if(stall_if4), .stall_id(stall_id4), .flush_id(flush_id4), .flush_ex(flush_ex4),
    .drain_ack(drain_ack4), .busy_regs(busy_regs4), .stall_count(stall_count4));

  int checks = 0;
  int failures = 0;

  // Reference model: set of in-flight registers, flush cycles left, drain pending flag, stall counts.
  logic [31:0] mbusy;
  int          mflush;
  bit          mdrain;
  int          mcnt16, mcnt4;

  typedef struct {
    logic idv, u1, u2, we, wbv, wbwe, redir, dreq;
    logic [4:0] rs1, rs2, rd, wbrd;
    logic e_stall, e_flush, e_ack;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int idv, int u1, int rs1, int u2, int rs2, int we, int rd,
                              int wbv, int wbwe, int wbrd, int redir, int dreq,
                              int es, int ef, int ea, int eb);
    vec_t v;
    v.idv = 1'(idv); v.u1 = 1'(u1); v.rs1 = 5'(rs1); v.u2 = 1'(u2); v.rs2 = 5'(rs2);
    v.we = 1'(we); v.rd = 5'(rd); v.wbv = 1'(wbv); v.wbwe = 1'(wbwe); v.wbrd = 5'(wbrd);
    v.redir = 1'(redir); v.dreq = 1'(dreq);
    v.e_stall = 1'(es); v.e_flush = 1'(ef); v.e_ack = 1'(ea); v.e_busy = 32'(eb);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rd_write_enable = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_write_addr = 0;
    wb_valid = 0; wb_rd_write_enable = 0; wb_rd_write_addr = 0;
    redirect = 0; drain_req = 0;
  endtask

  task automatic model_reset();
    mbusy = 0; mflush = 0; mdrain = 0; mcnt16 = 0; mcnt4 = 0;
  endtask

  function automatic logic m_flush();
    return redirect || (mflush > 0);
  endfunction

  function automatic logic m_stall();
    logic hz;
    hz = id_valid && ((id_uses_rs1 && mbusy[id_rs1_addr]) || (id_uses_rs2 && mbusy[id_rs2_addr]) ||
                      (id_rd_write_enable && mbusy[id_rd_write_addr]));
    if (m_flush()) return 1'b0;
    if (mdrain) return 1'b1;
    return hz;
  endfunction

  function automatic logic m_ack();
    return mdrain && !redirect && (mbusy == 0);
  endfunction

  task automatic model_check();
    chk("stall_if", {31'd0, stall_if}, {31'd0, m_stall()});
    chk("stall_id", {31'd0, stall_id}, {31'd0, m_stall()});
    chk("flush_id", {31'd0, flush_id}, {31'd0, m_flush()});
    chk("flush_ex", {31'd0, flush_ex}, {31'd0, m_flush()});
    chk("drain_ack", {31'd0, drain_ack}, {31'd0, m_ack()});
    chk("busy_regs", busy_regs, mbusy);
    chk("stall_count", 32'(stall_count), 32'(mcnt16));
    chk("stall_id_w4", {31'd0, stall_id4}, {31'd0, m_stall()});
    chk("flush_ex_w4", {31'd0, flush_ex4}, {31'd0, m_flush()});
    chk("drain_ack_w4", {31'd0, drain_ack4}, {31'd0, m_ack()});
    chk("busy_regs_w4", busy_regs4, mbusy);
    chk("stall_count_w4", 32'(stall_count4), 32'(mcnt4));
  endtask

  task automatic model_update();
    logic s, f, empty, set, clr;
    s = m_stall(); f = m_flush(); empty = (mbusy == 0);
    set = id_valid && id_rd_write_enable && (id_rd_write_addr != 0) && !s && !f;
    clr = wb_valid && wb_rd_write_enable && (wb_rd_write_addr != 0);
    if (clr) mbusy[wb_rd_write_addr] = 1'b0;
    if (set) mbusy[id_rd_write_addr] = 1'b1;
    mbusy[0] = 1'b0;
    if (s) begin
      if (mcnt16 < 65535) mcnt16++;
      if (mcnt4 < 15) mcnt4++;
    end
    if (redirect) begin
      mflush = FC - 1; mdrain = 0;
    end else if (mflush > 0) mflush--;
    else if (mdrain) begin
      if (empty) mdrain = 0;
    end else if (drain_req) mdrain = 1;
  endtask

  // Inputs are already applied and settled; compare, clock once, advance the model.
  task automatic step();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_busy", busy_regs, 32'd0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    chk("rst_stall", {31'd0, stall_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    do_reset();

    // Directed table: RAW stall, x0 writes, redirect flush, drain handshake.
    tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,0, 0,0, 0,0,0, 'h0));
    tbl.push_back(mk(1,1,1,0,0,1,2, 0,0,0, 0,0, 1,0,0, 'h2));
    tbl.push_back(mk(1,1,1,0,0,1,2, 0,0,0, 0,0, 1,0,0, 'h2));
    tbl.push_back(mk(1,1,1,0,0,1,2, 1,1,1, 0,0, 1,0,0, 'h2));
    tbl.push_back(mk(1,1,1,0,0,1,2, 0,0,0, 0,0, 0,0,0, 'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0, 'h4));
    tbl.push_back(mk(1,0,0,0,0,1,0, 1,1,2, 0,0, 0,0,0, 'h4));
    tbl.push_back(mk(1,1,0,1,0,0,0, 0,0,0, 0,0, 0,0,0, 'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0, 'h0));
    tbl.push_back(mk(1,0,0,0,0,1,3, 0,0,0, 0,0, 0,0,0, 'h0));
    tbl.push_back(mk(1,1,3,0,0,1,5, 0,0,0, 1,0, 0,1,0, 'h8));
    tbl.push_back(mk(1,1,3,0,0,1,5, 0,0,0, 0,0, 0,1,0, 'h8));
    tbl.push_back(mk(1,1,3,0,0,1,5, 0,0,0, 0,0, 1,0,0, 'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,3, 0,0, 0,0,0, 'h8));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0, 'h0));
    tbl.push_back(mk(1,0,0,0,0,1,1, 0,0,0, 0,0, 0,0,0, 'h0));
    tbl.push_back(mk(1,0,0,0,0,1,2, 0,0,0, 0,0, 0,0,0, 'h2));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,1, 0,0,0, 'h6));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,1, 0,1, 1,0,0, 'h6));
    tbl.push_back(mk(0,0,0,0,0,0,0, 1,1,2, 0,1, 1,0,0, 'h4));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,1, 1,0,1, 'h0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0, 'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      id_valid = tbl[i].idv; id_uses_rs1 = tbl[i].u1; id_rs1_addr = tbl[i].rs1;
      id_uses_rs2 = tbl[i].u2; id_rs2_addr = tbl[i].rs2;
      id_rd_write_enable = tbl[i].we; id_rd_write_addr = tbl[i].rd;
      wb_valid = tbl[i].wbv; wb_rd_write_enable = tbl[i].wbwe; wb_rd_write_addr = tbl[i].wbrd;
      redirect = tbl[i].redir; drain_req = tbl[i].dreq;
      #2;
      chk($sformatf("vec%0d_stall", i), {31'd0, stall_id}, {31'd0, tbl[i].e_stall});
      chk($sformatf("vec%0d_flush", i), {31'd0, flush_id}, {31'd0, tbl[i].e_flush});
      chk($sformatf("vec%0d_ack", i), {31'd0, drain_ack}, {31'd0, tbl[i].e_ack});
      chk($sformatf("vec%0d_busy", i), busy_regs, tbl[i].e_busy);
      step();
    end
    chk("table_stall_count", 32'(stall_count), 32'd7);

    // Reset in the middle of a flush with x4..x7 in flight.
    clear_inputs();
    for (int r = 4; r < 8; r++) begin
      id_valid = 1; id_rd_write_enable = 1; id_rd_write_addr = 5'(r);
      #2; step();
    end
    clear_inputs();
    redirect = 1;
    #2; chk("pre_rst_busy", busy_regs, 32'hF0); step();
    redirect = 0;
    #2; chk("mid_flush", {31'd0, flush_id}, 32'd1);
    rst = 1; redirect = 1;
    #1;
    model_reset();
    chk("rst_async_busy", busy_regs, 32'd0);
    chk("rst_async_flush", {30'd0, flush_id, flush_ex}, 32'd0);
    chk("rst_async_stall", {30'd0, stall_if, stall_id}, 32'd0);
    @(negedge clk);
    rst = 0; redirect = 0;
    id_valid = 1; id_uses_rs1 = 1; id_rs1_addr = 4; id_rd_write_enable = 1; id_rd_write_addr = 4;
    #2; chk("post_rst_stall", {31'd0, stall_id}, 32'd0); step();
    clear_inputs();
    #2; chk("post_rst_issue", busy_regs, 32'h10); step();

    // Saturation of the narrow counter under a long held hazard.
    do_reset();
    id_valid = 1; id_rd_write_enable = 1; id_rd_write_addr = 1;
    #2; step();
    clear_inputs();
    id_valid = 1; id_uses_rs1 = 1; id_rs1_addr = 1;
    for (int c = 0; c < 19; c++) begin
      #2; step();
    end
    #2;
    chk("sat_cnt4", 32'(stall_count4), 32'd15);
    chk("sat_cnt16", 32'(stall_count), 32'd19);

    // Randomized run against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic ack_now;
      id_valid = ($urandom_range(0, 9) < 7);
      id_uses_rs1 = $urandom_range(0, 1); id_rs1_addr = 5'($urandom_range(0, 7));
      id_uses_rs2 = $urandom_range(0, 1); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_write_enable = ($urandom_range(0, 3) != 0); id_rd_write_addr = 5'($urandom_range(0, 7));
      wb_valid = $urandom_range(0, 1); wb_rd_write_enable = ($urandom_range(0, 3) != 0);
      wb_rd_write_addr = 5'($urandom_range(0, 7));
      redirect = ($urandom_range(0, 19) == 0);
      if (!drain_req && $urandom_range(0, 29) == 0) drain_req = 1;
      ack_now = m_ack();
      #2; step();
      if (ack_now) drain_req = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
